// File: rtl/writeback_arbiter.sv
// writeback_arbiter: round-robin arbiter at the X->W boundary. Picks one of
// p_num_units execute-unit results, parks it in a single-entry stage and
// retires it over a val/rdy completion port that also drives the RF write.

// Per-unit front end: slices one unit's fields out of the flattened buses and
// zeroes them when the unit is not valid, so undriven data never reaches the
// selection mux.
module writeback_arbiter_lane #(
    parameter int p_seq_num_bits = 5
) (
    input  logic                                  val,
    input  logic [31:0]                           pc,
    input  logic [p_seq_num_bits-1:0]             seq_num,
    input  logic [4:0]                            waddr,
    input  logic [31:0]                           wdata,
    input  logic                                  wen,
    output logic [32+p_seq_num_bits+5+32+1-1:0]   msg
);
    typedef struct packed {
        logic [31:0]               pc;
        logic [p_seq_num_bits-1:0] seq_num;
        logic [4:0]                waddr;
        logic [31:0]               wdata;
        logic                      wen;
    } msg_t;

    msg_t m;

    // Gate every field with val so stale or unknown data is squashed here.
    always_comb begin
        m = '0;
        if (val) begin
            m.pc      = pc;
            m.seq_num = seq_num;
            m.waddr   = waddr;
            m.wdata   = wdata;
            m.wen     = wen;
        end
    end

    assign msg = m;
endmodule

module writeback_arbiter #(
    parameter int p_num_units    = 2,
    parameter int p_seq_num_bits = 5
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic [p_num_units-1:0]                 x_val,
    output logic [p_num_units-1:0]                 x_rdy,
    input  logic [32*p_num_units-1:0]              x_pc,
    input  logic [p_seq_num_bits*p_num_units-1:0]  x_seq_num,
    input  logic [5*p_num_units-1:0]               x_waddr,
    input  logic [32*p_num_units-1:0]              x_wdata,
    input  logic [p_num_units-1:0]                 x_wen,
    output logic                                   cmp_val,
    input  logic                                   cmp_rdy,
    output logic [31:0]                            cmp_pc,
    output logic [p_seq_num_bits-1:0]              cmp_seq_num,
    output logic [4:0]                             rf_waddr,
    output logic [31:0]                            rf_wdata,
    output logic                                   rf_wen
);
    localparam int PTR_W = $clog2(p_num_units);

    typedef struct packed {
        logic [31:0]               pc;
        logic [p_seq_num_bits-1:0] seq_num;
        logic [4:0]                waddr;
        logic [31:0]               wdata;
        logic                      wen;
    } msg_t;

    msg_t [p_num_units-1:0] lane_msg;
    msg_t                   stage;
    logic                   full;
    logic [PTR_W-1:0]       ptr;
    logic [PTR_W-1:0]       ptr_nxt;
    logic [PTR_W-1:0]       gnt_idx;
    logic                   gnt_any;
    logic                   cmp_fire;
    logic                   can_accept;
    logic                   x_fire;

    for (genvar i = 0; i < p_num_units; i++) begin : gen_lane
        writeback_arbiter_lane #(
            .p_seq_num_bits (p_seq_num_bits)
        ) u_lane (
            .val     (x_val[i]),
            .pc      (x_pc[32*i +: 32]),
            .seq_num (x_seq_num[p_seq_num_bits*i +: p_seq_num_bits]),
            .waddr   (x_waddr[5*i +: 5]),
            .wdata   (x_wdata[32*i +: 32]),
            .wen     (x_wen[i]),
            .msg     (lane_msg[i])
        );
    end

    assign cmp_fire   = full && cmp_rdy;
    // Draining entry frees the slot in the same cycle: flow-through at 1/cycle.
    assign can_accept = !full || cmp_fire;

    // Round-robin search: first valid unit at or above ptr, wrapping modulo N.
    always_comb begin
        int idx;
        idx     = 0;
        gnt_any = 1'b0;
        gnt_idx = '0;
        for (int k = 0; k < p_num_units; k++) begin
            idx = int'(ptr) + k;
            if (idx >= p_num_units) idx = idx - p_num_units;
            if (!gnt_any && x_val[idx]) begin
                gnt_any = 1'b1;
                gnt_idx = PTR_W'(idx);
            end
        end
    end

    // One-hot grant; held off entirely while reset is asserted.
    always_comb begin
        x_rdy = '0;
        if (rst && can_accept && gnt_any) x_rdy[gnt_idx] = 1'b1;
    end

    assign x_fire  = |x_rdy;
    assign ptr_nxt = (gnt_idx == PTR_W'(p_num_units - 1)) ? '0 : gnt_idx + 1'b1;

    // Stage register and pointer: a new capture overrides the drain.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            full  <= 1'b0;
            stage <= '0;
            ptr   <= '0;
        end else if (x_fire) begin
            full  <= 1'b1;
            stage <= lane_msg[gnt_idx];
            ptr   <= ptr_nxt;
        end else if (cmp_fire) begin
            full  <= 1'b0;
        end
    end

    assign cmp_val     = full;
    assign cmp_pc      = stage.pc;
    assign cmp_seq_num = stage.seq_num;
    assign rf_waddr    = stage.waddr;
    assign rf_wdata    = stage.wdata;
    // Write only on the retiring cycle, never to x0.
    assign rf_wen      = cmp_fire && stage.wen && (stage.waddr != 5'd0);
endmodule

// File: doc/writeback_arbiter.md
Name: writeback_arbiter

Overview:
- Downstream neighbour of the execute units (Multiplier, ALU, and others); sits at the X→W boundary.
- Accepts X__W-style messages from p_num_units execute units and arbitrates among them round-robin.
- Registers the winner in a single-entry pipeline stage, then retires it through a val/rdy completion interface.
- On completion, drives the architectural register-file write port.

Parameters:
- p_num_units, 2, number of upstream execute units (2..8)
- p_seq_num_bits, 5, width of the sequence number carried with each instruction

Ports:
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  asynchronous, active-low reset
- x_val  input  p_num_units  per-unit message valid
- x_rdy  output  p_num_units  per-unit ready (grant); at most one bit high
- x_pc  input  32*p_num_units  per-unit pc; unit i occupies bits [32i+31:32i]
- x_seq_num  input  p_seq_num_bits*p_num_units  per-unit sequence number
- x_waddr  input  5*p_num_units  per-unit destination register
- x_wdata  input  32*p_num_units  per-unit result data
- x_wen  input  p_num_units  per-unit write enable
- cmp_val  output  1  completion valid
- cmp_rdy  input  1  completion ready (commit/ROB side)
- cmp_pc  output  32  retired pc
- cmp_seq_num  output  p_seq_num_bits  retired sequence number
- rf_waddr  output  5  register-file write address
- rf_wdata  output  32  register-file write data
- rf_wen  output  1  register-file write strobe

Behaviour:
- Reset (rst low, asynchronous):
  - stage register empty: cmp_val=0.
  - cmp_pc, cmp_seq_num, rf_waddr and rf_wdata all 0; rf_wen=0.
  - Round-robin pointer = 0.
  - x_rdy=0 while rst is low.
- Stage register: one entry holding pc, seq_num, waddr, wdata, wen.
- Acceptance:
  - stage_can_accept = !full || (cmp_val && cmp_rdy), giving pipelined flow-through.
  - Sustained throughput is 1 msg/cycle with cmp_rdy held high.
- Arbitration (combinational, each cycle):
  - If stage_can_accept, grant the first unit i with x_val[i]=1, searching from pointer upward modulo p_num_units.
  - x_rdy[i]=1 only for the granted unit; all others 0.
  - x_rdy never depends on x_val of non-candidate units in a way that creates a combinational loop through x_val.
- Transfer: unit i fires when x_val[i] && x_rdy[i]. On that edge:
  - The message is captured into the stage register.
  - pointer ← (i+1) mod p_num_units.
- No fire → pointer unchanged. Grants are therefore strictly fair: a unit with x_val held high waits at most p_num_units-1 transfers.
- Latency: a message accepted at edge N appears on cmp_* in cycle N (registered output). Minimum one cycle from x fire to cmp_val.
- Completion: cmp_val=full.
  - On cmp_val && cmp_rdy, the entry leaves.
  - If no new transfer occurs in the same cycle, full←0.
  - Simultaneous fire-out and fire-in: the register is overwritten and stays full.
- Register-file write:
  - rf_wen = cmp_val && cmp_rdy && wen && (waddr != 0). Writes to x0 are suppressed.
  - rf_waddr and rf_wdata mirror the stage register at all times.
  - rf_wen is asserted only in the completion cycle; a stalled entry never writes twice.
- Backpressure: cmp_rdy=0 with the stage full → all x_rdy=0 and the entry holds stable. cmp_* outputs must not change while cmp_val=1 and cmp_rdy=0.
- Reset mid-operation: the pending entry is discarded with no rf_wen pulse. Pointer returns to 0.
- All valids low: no grant, pointer unchanged; the stage drains if cmp_rdy=1.
- Data on non-granted ports is ignored. X on x_* data while x_val=0 must not propagate.

Test Plan:
- Single message: unit 0 sends pc=0x200, seq=3, waddr=5, wdata=0x0000002A, wen=1, with cmp_rdy=1 → next cycle cmp_val=1, cmp_pc=0x200, cmp_seq_num=3, rf_wen=1, rf_waddr=5, rf_wdata=0x2A.
- x0 suppression: unit 1 sends waddr=0, wdata=0xDEADBEEF, wen=1 → cmp_val=1, rf_wen=0.
- Round-robin fairness: p_num_units=3, all units valid continuously, each with a distinct seq (0, 1, 2 repeated) → completion order 0,1,2,0,1,2, one per cycle, no bubbles.
- Backpressure: hold cmp_rdy=0 for 4 cycles with the stage full and unit 1 valid → x_rdy=0 and cmp_* stable, rf_wen never pulses; release → original entry retires, then unit 1's message the following cycle.
- wen=0 message (e.g. a store-like op) → cmp_val=1 with correct seq_num, rf_wen=0.
- Async reset: assert rst low mid-cycle while the stage holds seq=7 → cmp_val drops immediately with no rf_wen. After release, a unit 1 message is granted before unit 0 only if unit 0 is not valid (pointer=0).
